// File: rtl/sramx_responder_if.sv
// ---------------------------------------------------------------------------
// sramx_responder_if
//   SRAM-like (sramx) request/response bundle between a bus converter
//   (master) and the memory-side responder (slave).
//
//   en     master->slave  request valid this cycle
//   wen    master->slave  byte write enables, 4'b0000 = read
//   addr   master->slave  virtual byte address (addr[1:0] ignored)
//   wdata  master->slave  write data, lane i = wdata[8i+7:8i]
//   rdata  slave->master  registered response word
//   err    slave->master  one-cycle unmapped-access flag, aligned with rdata
// ---------------------------------------------------------------------------
interface sramx_responder_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output en,
        output wen,
        output addr,
        output wdata,
        input  rdata,
        input  err
    );

    modport slave (
        input  en,
        input  wen,
        input  addr,
        input  wdata,
        output rdata,
        output err
    );
endinterface

// File: rtl/sramx_responder.sv
// ---------------------------------------------------------------------------
// sramx_responder
//   Memory-side responder for the sramx interface. Translates MIPS
//   kseg0/kseg1 virtual addresses to physical, serves word reads and
//   byte-masked writes from an on-chip word array with one-cycle latency,
//   and maps a free-running 32-bit timer register at TIMER_ADDR.
//
//   Parameters
//     DEPTH_LOG2  log2 of RAM words; RAM covers physical [0, 4*2^DEPTH_LOG2)
//                 (must be below 30)
//     TIMER_ADDR  physical address of the timer word
//
//   Ports
//     clk     rising-edge clock
//     resetn  asynchronous active-low reset (rdata, err, timer only)
//     bus     sramx slave port (en, wen, addr, wdata -> rdata, err)
// ---------------------------------------------------------------------------
module sramx_responder #(
    parameter int unsigned DEPTH_LOG2 = 16,
    parameter logic [31:0] TIMER_ADDR = 32'h1FAF_F000
) (
    input  logic              clk,
    input  logic              resetn,
    sramx_responder_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    // Word array; deliberately not reset so it survives a core reset.
    logic [31:0] mem [DEPTH];

    logic [31:0]           paddr;
    logic [DEPTH_LOG2-1:0] index;
    logic                  ram_hit;
    logic                  timer_hit;
    logic                  is_write;
    logic [1:0]            paddr_lsb_unused;

    logic [31:0] timer;
    logic [31:0] timer_next;
    logic [31:0] rdata_q;
    logic        err_q;

    // ------------------------------------------------------------------
    // Address translation and decode
    // ------------------------------------------------------------------
    always_comb begin
        if (bus.addr[31:30] == 2'b10) begin
            paddr = {3'b000, bus.addr[28:0]};
        end else begin
            paddr = bus.addr;
        end
        ram_hit          = (paddr[31:DEPTH_LOG2+2] == '0);
        // RAM takes precedence should TIMER_ADDR ever fall inside it.
        timer_hit        = !ram_hit && (paddr[31:2] == TIMER_ADDR[31:2]);
        index            = paddr[DEPTH_LOG2+1:2];
        is_write         = (bus.wen != 4'b0000);
        paddr_lsb_unused = paddr[1:0];
    end

    // ------------------------------------------------------------------
    // Timer next value: a write replaces the increment for that edge.
    // ------------------------------------------------------------------
    always_comb begin
        timer_next = timer + 32'd1;
        if (bus.en && timer_hit && is_write) begin
            timer_next = timer;
            for (int unsigned i = 0; i < 4; i++) begin
                if (bus.wen[i]) begin
                    timer_next[8*i +: 8] = bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM byte-lane writes (no reset on the array)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (resetn && bus.en && ram_hit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (bus.wen[i]) begin
                    mem[index][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response and timer registers. Reads sample the array and timer
    // before this edge's update, giving read-before-write on writes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            timer   <= '0;
        end else begin
            timer <= timer_next;
            err_q <= 1'b0;
            if (bus.en) begin
                if (ram_hit) begin
                    rdata_q <= mem[index];
                end else if (timer_hit) begin
                    rdata_q <= timer;
                end else begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_sramx_responder.sv
// ---------------------------------------------------------------------------
// tb_sramx_responder
//   Self-checking bench for sramx_responder. A behavioural model (byte map
//   for RAM, integer timer) predicts rdata/err; a compare process checks the
//   DUT on every falling edge, and directed literal expectations pin the
//   model. Inputs change on falling edges; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_sramx_responder;

    localparam int unsigned DL2       = 16;
    localparam logic [31:0] TIMER_PA  = 32'h1FAF_F000;
    localparam logic [31:0] RAM_BYTES = 32'h4 << DL2;

    logic clk;
    logic resetn;

    sramx_responder_if bus ();

    sramx_responder #(
        .DEPTH_LOG2 (DL2),
        .TIMER_ADDR (TIMER_PA)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit [7:0]    mem_m [bit [31:0]];
    logic [31:0] tm      = '0;
    logic [31:0] exp_rd  = '0;
    logic [31:0] exp_msk = '1;
    logic        exp_er  = 1'b0;

    function automatic logic [31:0] xlate(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF)
            return a & 32'h1FFF_FFFF;
        return a;
    endfunction

    always @(posedge clk or negedge resetn) begin
        logic [31:0] pa;
        logic [31:0] wa;
        logic [31:0] nt;
        if (!resetn) begin
            exp_rd  = '0;
            exp_er  = 1'b0;
            exp_msk = '1;
            tm      = '0;
        end else begin
            pa     = xlate(bus.addr);
            nt     = tm + 32'd1;
            exp_er = 1'b0;
            if (bus.en) begin
                if (pa < RAM_BYTES) begin
                    wa = pa & ~32'd3;
                    for (int b = 0; b < 4; b++) begin
                        if (mem_m.exists(wa + b)) begin
                            exp_rd[8*b +: 8]  = mem_m[wa + b];
                            exp_msk[8*b +: 8] = 8'hFF;
                        end else begin
                            exp_rd[8*b +: 8]  = 8'h00;
                            exp_msk[8*b +: 8] = 8'h00;
                        end
                    end
                    for (int b = 0; b < 4; b++)
                        if (bus.wen[b]) mem_m[wa + b] = bus.wdata[8*b +: 8];
                end else if ((pa >> 2) == (TIMER_PA >> 2)) begin
                    exp_rd  = tm;
                    exp_msk = '1;
                    if (bus.wen != 4'b0000) begin
                        nt = tm;
                        for (int b = 0; b < 4; b++)
                            if (bus.wen[b]) nt[8*b +: 8] = bus.wdata[8*b +: 8];
                    end
                end else begin
                    exp_rd  = '0;
                    exp_msk = '1;
                    exp_er  = 1'b1;
                end
            end
            tm = nt;
        end
    end

    // Cycle compare against the model
    always @(negedge clk) begin
        tests++;
        if ((((bus.rdata ^ exp_rd) & exp_msk) != 32'd0) || (bus.err !== exp_er)) begin
            failed++;
            $display("FAIL model_cycle t=%0t: got rdata=%h err=%b, want rdata=%h (mask %h) err=%b",
                     $time, bus.rdata, bus.err, exp_rd, exp_msk, exp_er);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc(input logic e, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d);
        bus.en    = e;
        bus.wen   = w;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
    endtask

    task automatic pin(input string name, input logic [31:0] d, input logic e);
        tests++;
        if (bus.rdata !== d || bus.err !== e) begin
            failed++;
            $display("FAIL %s: got rdata=%h err=%b, want rdata=%h err=%b",
                     name, bus.rdata, bus.err, d, e);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        logic [31:0] seg;
        logic [31:0] segs [3];
        segs[0] = 32'h0000_0000;
        segs[1] = 32'h8000_0000;
        segs[2] = 32'hA000_0000;
        seg = segs[$urandom_range(0, 2)];
        k = $urandom_range(0, 19);
        if (k < 12)
            return seg + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
        if (k < 14)
            return seg + (RAM_BYTES - 4 - 32'($urandom_range(0, 3)) * 4);
        if (k < 16)
            return seg + TIMER_PA + 32'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0:       return RAM_BYTES + 32'($urandom_range(0, 15)) * 4;
            1:       return 32'h1000_0000 | ($urandom & 32'h000F_FFFF);
            2:       return 32'hC000_0000 | ($urandom & 32'h0FFF_FFFF);
            default: return TIMER_PA + 32'd4;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Directed sequence followed by random traffic
    // ------------------------------------------------------------------
    initial begin
        bus.en    = 1'b0;
        bus.wen   = 4'b0000;
        bus.addr  = '0;
        bus.wdata = '0;
        resetn    = 1'b1;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        pin("reset_values", 32'h0, 1'b0);
        resetn = 1'b1;

        // Timer: read at the 10th edge after release returns 9
        repeat (9) cyc(1'b0, 4'h0, 32'h0, 32'h0);
        cyc(1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
        pin("timer_10th_edge", 32'd9, 1'b0);

        cyc(1'b1, 4'hF, 32'h1FAF_F000, 32'h0000_0100);
        cyc(1'b0, 4'h0, 32'h0, 32'h0);
        cyc(1'b1, 4'h0, 32'h1FAF_F000, 32'h0);
        pin("timer_write_then_read", 32'h0000_0101, 1'b0);

        cyc(1'b1, 4'hF, 32'hBFAF_F000, 32'hFFFF_FFFF);
        cyc(1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
        pin("timer_pre_wrap", 32'hFFFF_FFFF, 1'b0);
        cyc(1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
        pin("timer_wrap", 32'h0, 1'b0);

        // RAM aliasing, read-after-write, byte lanes, read-before-write
        cyc(1'b1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF);
        cyc(1'b1, 4'h0, 32'hA000_0010, 32'h0);
        pin("ram_alias_raw", 32'hDEAD_BEEF, 1'b0);
        cyc(1'b1, 4'b0101, 32'h8000_0010, 32'h1122_3344);
        pin("ram_read_before_write", 32'hDEAD_BEEF, 1'b0);
        cyc(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        pin("ram_byte_merge", 32'hDE22_BE44, 1'b0);

        // Unmapped accesses
        cyc(1'b1, 4'h0, 32'h1000_0000, 32'h0);
        pin("unmapped_read", 32'h0, 1'b1);
        cyc(1'b0, 4'h0, 32'h0, 32'h0);
        pin("unmapped_err_one_cycle", 32'h0, 1'b0);
        cyc(1'b1, 4'hF, 32'h1FAF_F000, 32'h0000_0500);
        cyc(1'b1, 4'hF, 32'h1000_0010, 32'hFFFF_FFFF);
        pin("unmapped_write", 32'h0, 1'b1);
        cyc(1'b1, 4'h0, 32'h1FAF_F000, 32'h0);
        pin("timer_after_unmapped_write", 32'h0000_0501, 1'b0);
        cyc(1'b1, 4'h0, 32'hA000_0010, 32'h0);
        pin("ram_after_unmapped_write", 32'hDE22_BE44, 1'b0);

        // RAM top boundary
        cyc(1'b1, 4'hF, RAM_BYTES - 4, 32'hCAFE_F00D);
        cyc(1'b1, 4'h0, 32'h8000_0000 | (RAM_BYTES - 4), 32'h0);
        pin("ram_top_word", 32'hCAFE_F00D, 1'b0);
        cyc(1'b1, 4'h0, RAM_BYTES, 32'h0);
        pin("ram_end_unmapped", 32'h0, 1'b1);

        // Asynchronous reset while a read response is outstanding
        bus.en   = 1'b1;
        bus.wen  = 4'h0;
        bus.addr = 32'hA000_0010;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        bus.en = 1'b0;
        #1;
        pin("async_reset_mid_read", 32'h0, 1'b0);
        @(negedge clk);
        #1 resetn = 1'b1;
        cyc(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        pin("ram_survives_reset", 32'hDE22_BE44, 1'b0);

        // Random traffic checked by the model
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 3) != 0),
                ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                rand_addr(), $urandom);
        end
        cyc(1'b0, 4'h0, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
